karatsuba_leaf_issuer: RTL



---
 rtl/karatsuba_leaf_issuer.sv | 132 +++++++++++++
 1 files changed

// File: rtl/karatsuba_leaf_issuer.sv
// Karatsuba operand splitter over GF(2): latches one operand pair and streams
// its 3^LEVELS leaf operand pairs in ascending index order, one per handshake.
module karatsuba_leaf_issuer #(
    parameter int N      = 32,
    parameter int LEVELS = 2,
    localparam int W      = N >> LEVELS,
    localparam int LEAVES = 3 ** LEVELS
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_a,
    input  logic [N-1:0] in_b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_a,
    output logic [W-1:0] out_b,
    output logic [4:0]   out_idx,
    output logic         out_last,
    output logic         busy
);

    typedef enum logic [0:0] {IDLE = 1'b0, ISSUE = 1'b1} state_t;

    localparam logic [4:0] LAST_IDX = 5'(LEAVES - 1);

    state_t         state_q, state_d;
    logic [N-1:0]   a_q, a_d, b_q, b_d;
    logic [4:0]     idx_q, idx_d;
    logic [W-1:0]   out_a_q, out_a_d, out_b_q, out_b_d;
    logic           out_last_q, out_last_d;
    logic           load_s;

    // Walk the base-3 digits of idx (most significant first), narrowing to hi, lo or hi^lo.
    function automatic logic [W-1:0] leaf_of(input logic [N-1:0] op, input logic [4:0] idx);
        logic [N-1:0] x, hi, lo, mask;
        int unsigned  rem, span, d, w;
        x    = op;
        rem  = {27'd0, idx};
        span = 32'(LEAVES);
        w    = 32'(N);
        for (int j = 0; j < LEVELS; j++) begin
            span = span / 32'd3;
            d    = rem / span;
            rem  = rem % span;
            w    = w >> 1;
            mask = {N{1'b1}} >> (32'(N) - w);
            hi   = (x >> w) & mask;
            lo   = x & mask;
            case (d)
                32'd0:   x = hi;
                32'd1:   x = lo;
                default: x = hi ^ lo;
            endcase
        end
        return x[W-1:0];
    endfunction

    // Next-state, operand latch and leaf register update.
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        idx_d      = idx_q;
        out_a_d    = out_a_q;
        out_b_d    = out_b_q;
        out_last_d = out_last_q;
        load_s     = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    idx_d   = 5'd0;
                    load_s  = 1'b1;
                    state_d = ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                if (out_ready && (idx_q == LAST_IDX)) begin
                    state_d = IDLE;
                end else if (out_ready) begin
                    idx_d  = idx_q + 5'd1;
                    load_s = 1'b1;
                end else begin
                    state_d = ISSUE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (load_s) begin
            out_a_d    = leaf_of(a_d, idx_d);
            out_b_d    = leaf_of(b_d, idx_d);
            out_last_d = (idx_d == LAST_IDX);
        end else begin
            out_last_d = out_last_q;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            idx_q      <= 5'd0;
            out_a_q    <= '0;
            out_b_q    <= '0;
            out_last_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            idx_q      <= idx_d;
            out_a_q    <= out_a_d;
            out_b_q    <= out_b_d;
            out_last_q <= out_last_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == ISSUE);
    assign busy      = (state_q == ISSUE);
    assign out_idx   = idx_q;
    assign out_a     = out_a_q;
    assign out_b     = out_b_q;
    assign out_last  = out_last_q;

endmodule
